// File: rtl/music_note_sequencer.sv
// Music note sequencer: walks an 8-bit note ROM from address 0, decodes each
// byte into pitch and duration, and drives a square-wave buzzer pin.
module music_note_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int TICK_DIV    = 6250000,
  parameter int PITCH_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [7:0]            rom_data_i,
  output logic                  buzzer_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            note_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_PLAY   = 2'd3;

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        state;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        beat_cnt;
  logic [16:0]       hp_cnt;
  logic [16:0]       half_q;
  logic              tone_on;

  logic [16:0]       base;
  logic [16:0]       shifted;
  logic [16:0]       half_calc;
  logic              end_marker;
  logic              tick_last;
  logic              addr_last;

  // Half-period lookup for the byte on the ROM bus, scaled by octave; never 0
  always_comb begin
    base = 17'd0;
    case (rom_data_i[2:0])
      3'd1:    base = 17'd95556;
      3'd2:    base = 17'd85131;
      3'd3:    base = 17'd75843;
      3'd4:    base = 17'd71586;
      3'd5:    base = 17'd63776;
      3'd6:    base = 17'd56818;
      3'd7:    base = 17'd50619;
      default: base = 17'd0;
    endcase
    shifted    = base >> (int'(rom_data_i[4:3]) + PITCH_SHIFT);
    half_calc  = (shifted == 17'd0) ? 17'd1 : shifted;
    end_marker = (rom_data_i[4:0] == 5'b11000);
    tick_last  = (tick_cnt == TICK_LAST);
    addr_last  = &rom_addr_o;
  end

  // Sequencer FSM: fetch/decode/play loop with stop abort and end-of-song pulse
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rom_addr_o <= '0;
      buzzer_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      note_o     <= 8'd0;
      tick_cnt   <= '0;
      beat_cnt   <= 3'd0;
      hp_cnt     <= 17'd0;
      half_q     <= 17'd0;
      tone_on    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state != ST_IDLE && stop_i) begin
        state    <= ST_IDLE;
        busy_o   <= 1'b0;
        buzzer_o <= 1'b0;
        note_o   <= 8'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && !stop_i) begin
              state      <= ST_FETCH;
              rom_addr_o <= '0;
              busy_o     <= 1'b1;
            end
          end
          ST_FETCH: begin
            state <= ST_DECODE;
          end
          ST_DECODE: begin
            if (end_marker) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              note_o   <= rom_data_i;
              beat_cnt <= rom_data_i[7:5];
              tick_cnt <= '0;
              hp_cnt   <= 17'd0;
              buzzer_o <= 1'b0;
              half_q   <= half_calc;
              tone_on  <= (rom_data_i[2:0] != 3'd0);
              state    <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (tone_on) begin
              if (hp_cnt == half_q - 17'd1) begin
                hp_cnt   <= 17'd0;
                buzzer_o <= ~buzzer_o;
              end else begin
                hp_cnt <= hp_cnt + 17'd1;
              end
            end
            if (tick_last) begin
              tick_cnt <= '0;
              if (beat_cnt == 3'd0) begin
                note_o   <= 8'd0;
                buzzer_o <= 1'b0;
                if (addr_last) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                end else begin
                  rom_addr_o <= rom_addr_o + ADDR_WIDTH'(1);
                  state      <= ST_FETCH;
                end
              end else begin
                beat_cnt <= beat_cnt - 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
